// File: rtl/shade_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// shade_ramp_ctrl
//
// Purpose:
//   Decodes a one-hot time-of-day code (or a manual override) into a target
//   shade level, registers it, and then walks the physical shade position
//   toward that target one level at a time at a programmable step rate.
//   It sits between the time-of-day / user-light logic and the shade motor
//   driver, which consumes wshade and step_pulse.
//
// Parameters:
//   LEVEL_W       width of all shade levels
//   STEP_DIV      clock cycles per one-level step (>= 1)
//   NIGHT_LEVEL   target for tcode 0001
//   EVENING_LEVEL target for tcode 0010
//   DAY_LEVEL     target for tcode 0000 and 1000
//
// Ports:
//   clk        in   system clock, all state updates on rising edge
//   rst        in   synchronous active-high reset
//   tcode      in   time code: 0000 off, 0001 night, 0010 evening,
//                   0100 user, 1000 day; anything else holds the target
//   ulight     in   user light degree, used when tcode = 0100
//   ovr_en     in   manual override enable, highest priority
//   ovr_level  in   override target level
//   wshade     out  current shade position (registered)
//   target     out  registered target level
//   moving     out  high while the shade is ramping
//   dir_up     out  high while ramping upward
//   step_pulse out  one-cycle pulse in the cycle after wshade changes
//   at_target  out  wshade == target (combinational)
// ---------------------------------------------------------------------------
module shade_ramp_ctrl #(
  parameter int                 LEVEL_W       = 4,
  parameter int                 STEP_DIV      = 4,
  parameter logic [LEVEL_W-1:0] NIGHT_LEVEL   = '1,
  parameter logic [LEVEL_W-1:0] EVENING_LEVEL = LEVEL_W'(11),
  parameter logic [LEVEL_W-1:0] DAY_LEVEL     = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         tcode,
  input  logic [LEVEL_W-1:0] ulight,
  input  logic               ovr_en,
  input  logic [LEVEL_W-1:0] ovr_level,
  output logic [LEVEL_W-1:0] wshade,
  output logic [LEVEL_W-1:0] target,
  output logic               moving,
  output logic               dir_up,
  output logic               step_pulse,
  output logic               at_target
);

  // A divide-by-one build still needs a one-bit prescaler so the
  // "step due" compare has something to look at; it simply never counts.
  localparam int                PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2
  } state_t;

  state_t             state;
  logic [PRE_W-1:0]   prescaler;
  logic [LEVEL_W-1:0] target_next;
  logic [LEVEL_W-1:0] wshade_inc;
  logic [LEVEL_W-1:0] wshade_dec;
  logic               tgt_above;
  logic               tgt_below;
  logic               step_due;

  // Target decode in priority order. A non-one-hot time code is treated as
  // noise on the time bus and deliberately keeps the last registered target.
  always_comb begin
    target_next = target;
    if (ovr_en) begin
      target_next = ovr_level;
    end else begin
      case (tcode)
        4'b0000, 4'b1000: target_next = DAY_LEVEL;
        4'b0001:          target_next = NIGHT_LEVEL;
        4'b0010:          target_next = EVENING_LEVEL;
        4'b0100:          target_next = ulight;
        default:          target_next = target;
      endcase
    end
  end

  // Neighbouring positions, clamped so the shade can never wrap around
  // even if the compare logic were ever bypassed.
  always_comb begin
    wshade_inc = (wshade == '1) ? wshade : wshade + LEVEL_W'(1);
    wshade_dec = (wshade == '0) ? wshade : wshade - LEVEL_W'(1);
  end

  // Unsigned comparisons of the registered target against the position and
  // the prescaler terminal count that paces each step.
  always_comb begin
    tgt_above = (target > wshade);
    tgt_below = (target < wshade);
    step_due  = (prescaler == PRE_LAST);
  end

  // Main controller. The target is re-registered every edge; the FSM always
  // works on the previously registered target, which is what gives the one
  // extra edge between an input change and the start of a move.
  // A change of target on the same side of the shade keeps the prescaler
  // running so the motor cadence is not disturbed; a reversal or an exact
  // match restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prescaler  <= '0;
      wshade     <= '0;
      target     <= '0;
      moving     <= 1'b0;
      dir_up     <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      target     <= target_next;
      step_pulse <= 1'b0;

      case (state)
        IDLE: begin
          prescaler <= '0;
          if (tgt_above) begin
            state  <= MOVE_UP;
            moving <= 1'b1;
            dir_up <= 1'b1;
          end else if (tgt_below) begin
            state  <= MOVE_DN;
            moving <= 1'b1;
            dir_up <= 1'b0;
          end
        end

        MOVE_UP: begin
          if (tgt_above) begin
            if (step_due) begin
              wshade     <= wshade_inc;
              prescaler  <= '0;
              step_pulse <= 1'b1;
              if (wshade_inc == target) begin
                state  <= IDLE;
                moving <= 1'b0;
                dir_up <= 1'b0;
              end
            end else begin
              prescaler <= prescaler + PRE_W'(1);
            end
          end else if (tgt_below) begin
            state     <= MOVE_DN;
            prescaler <= '0;
            dir_up    <= 1'b0;
          end else begin
            state     <= IDLE;
            prescaler <= '0;
            moving    <= 1'b0;
            dir_up    <= 1'b0;
          end
        end

        MOVE_DN: begin
          if (tgt_below) begin
            if (step_due) begin
              wshade     <= wshade_dec;
              prescaler  <= '0;
              step_pulse <= 1'b1;
              if (wshade_dec == target) begin
                state  <= IDLE;
                moving <= 1'b0;
                dir_up <= 1'b0;
              end
            end else begin
              prescaler <= prescaler + PRE_W'(1);
            end
          end else if (tgt_above) begin
            state     <= MOVE_UP;
            prescaler <= '0;
            dir_up    <= 1'b1;
          end else begin
            state     <= IDLE;
            prescaler <= '0;
            moving    <= 1'b0;
            dir_up    <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          prescaler <= '0;
          moving    <= 1'b0;
          dir_up    <= 1'b0;
        end
      endcase
    end
  end

  assign at_target = (wshade == target);

endmodule

// File: tb/tb_shade_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shade_ramp_ctrl
//
// Drives a STEP_DIV=4 and a STEP_DIV=1 instance of shade_ramp_ctrl from the
// same inputs. A behavioural model (position, direction, cycles spent in the
// current direction) predicts every output of both instances; a negedge
// process compares them each cycle. Directed scenarios add hand-computed
// literal checks that pin the model to known ramp timings.
// ---------------------------------------------------------------------------
module tb_shade_ramp_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] tcode;
  logic [3:0] ulight;
  logic       ovr_en;
  logic [3:0] ovr_level;

  logic [3:0] wshade4, target4, wshade1, target1;
  logic       moving4, dirup4, pulse4, attgt4;
  logic       moving1, dirup1, pulse1, attgt1;

  int vectors;
  int miscompares;
  bit compareOn;

  int mTgt[2];
  int mPos[2];
  int mDir[2];
  int mEl[2];
  int mPulse[2];
  int mDiv[2];
  int want;

  shade_ramp_ctrl #(.LEVEL_W(4), .STEP_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .tcode(tcode), .ulight(ulight),
    .ovr_en(ovr_en), .ovr_level(ovr_level),
    .wshade(wshade4), .target(target4), .moving(moving4), .dir_up(dirup4),
    .step_pulse(pulse4), .at_target(attgt4)
  );

  shade_ramp_ctrl #(.LEVEL_W(4), .STEP_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .tcode(tcode), .ulight(ulight),
    .ovr_en(ovr_en), .ovr_level(ovr_level),
    .wshade(wshade1), .target(target1), .moving(moving1), .dir_up(dirup1),
    .step_pulse(pulse1), .at_target(attgt1)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Target selection straight from the decode rules.
  function automatic int decodeTarget(int prev, logic [3:0] tc, int ul, bit oe, int ol);
    if (oe) return ol;
    case (tc)
      4'b0000, 4'b1000: return 0;
      4'b0001:          return 15;
      4'b0010:          return 11;
      4'b0100:          return ul;
      default:          return prev;
    endcase
  endfunction

  // Behavioural model: the shade heads toward the previously registered
  // target; after STEP_DIV consecutive edges spent travelling in one
  // direction it moves one level. Any change of wanted direction restarts
  // the count.
  initial begin
    mDiv[0] = 4;
    mDiv[1] = 1;
    for (int i = 0; i < 2; i++) begin
      mTgt[i] = 0; mPos[i] = 0; mDir[i] = 0; mEl[i] = 0; mPulse[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mTgt[i] = 0; mPos[i] = 0; mDir[i] = 0; mEl[i] = 0; mPulse[i] = 0;
      end else begin
        want = (mTgt[i] > mPos[i]) ? 1 : ((mTgt[i] < mPos[i]) ? -1 : 0);
        mPulse[i] = 0;
        if (mDir[i] != 0 && want == mDir[i]) begin
          mEl[i] = mEl[i] + 1;
          if (mEl[i] == mDiv[i]) begin
            mPos[i] = mPos[i] + mDir[i];
            mEl[i] = 0;
            mPulse[i] = 1;
            if (mPos[i] == mTgt[i]) mDir[i] = 0;
          end
        end else begin
          mDir[i] = want;
          mEl[i] = 0;
        end
        mTgt[i] = decodeTarget(mTgt[i], tcode, int'(ulight), ovr_en, int'(ovr_level));
      end
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("d4.wshade", int'(wshade4), mPos[0]);
      checkOutput("d4.target", int'(target4), mTgt[0]);
      checkOutput("d4.moving", int'(moving4), (mDir[0] != 0) ? 1 : 0);
      checkOutput("d4.dir_up", int'(dirup4), (mDir[0] > 0) ? 1 : 0);
      checkOutput("d4.step_pulse", int'(pulse4), mPulse[0]);
      checkOutput("d4.at_target", int'(attgt4), (mPos[0] == mTgt[0]) ? 1 : 0);
      checkOutput("d1.wshade", int'(wshade1), mPos[1]);
      checkOutput("d1.target", int'(target1), mTgt[1]);
      checkOutput("d1.moving", int'(moving1), (mDir[1] != 0) ? 1 : 0);
      checkOutput("d1.dir_up", int'(dirup1), (mDir[1] > 0) ? 1 : 0);
      checkOutput("d1.step_pulse", int'(pulse1), mPulse[1]);
      checkOutput("d1.at_target", int'(attgt1), (mPos[1] == mTgt[1]) ? 1 : 0);
    end
  end

  // Drive a new input set at a falling edge and hold it for n cycles.
  task automatic applyStimulus(input bit r, input logic [3:0] tc, input logic [3:0] ul,
                               input bit oe, input logic [3:0] ol, input int n);
    @(negedge clk);
    rst       = r;
    tcode     = tc;
    ulight    = ul;
    ovr_en    = oe;
    ovr_level = ol;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int  pulses;
    bit  found;
    int  sel;
    logic [3:0] tc;

    vectors     = 0;
    miscompares = 0;
    compareOn   = 1'b0;
    rst = 1'b1; tcode = 4'b0000; ulight = 4'd0; ovr_en = 1'b0; ovr_level = 4'd0;

    // Reset state.
    applyStimulus(1'b1, 4'b0000, 4'd0, 1'b0, 4'd0, 2);
    compareOn = 1'b1;
    checkOutput("rst.wshade", int'(wshade4), 0);
    checkOutput("rst.target", int'(target4), 0);
    checkOutput("rst.moving", int'(moving4), 0);
    checkOutput("rst.step_pulse", int'(pulse4), 0);

    // Night ramp 0 -> 15 at four cycles per level.
    applyStimulus(1'b0, 4'b0001, 4'd0, 1'b0, 4'd0, 1);
    pulses = 0;
    for (int e = 1; e <= 64; e++) begin
      @(posedge clk); #1;
      if (pulse4) pulses++;
      if (e == 1)  checkOutput("up.target_e1", int'(target4), 15);
      if (e == 1)  checkOutput("up.moving_e1", int'(moving4), 0);
      if (e == 2)  checkOutput("up.moving_e2", int'(moving4), 1);
      if (e == 6)  checkOutput("up.wshade_e6", int'(wshade4), 1);
      if (e == 61) checkOutput("up.wshade_e61", int'(wshade4), 14);
      if (e == 62) checkOutput("up.wshade_e62", int'(wshade4), 15);
      if (e == 62) checkOutput("up.moving_e62", int'(moving4), 0);
      if (e == 62) checkOutput("up.at_target_e62", int'(attgt4), 1);
    end
    checkOutput("up.pulse_count", pulses, 15);

    // Down to the user level 6: nine steps.
    applyStimulus(1'b0, 4'b0100, 4'd6, 1'b0, 4'd0, 1);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e == 2)  checkOutput("dn.moving_e2", int'(moving4), 1);
      if (e == 2)  checkOutput("dn.dir_up_e2", int'(dirup4), 0);
      if (e == 37) checkOutput("dn.wshade_e37", int'(wshade4), 7);
      if (e == 38) checkOutput("dn.wshade_e38", int'(wshade4), 6);
      if (e == 40) checkOutput("dn.moving_e40", int'(moving4), 0);
    end

    // Evening, then an illegal code holds the target, then day ramps to 0.
    applyStimulus(1'b0, 4'b0010, 4'd6, 1'b0, 4'd0, 1);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("eve.target", int'(target4), 11);
    checkOutput("eve.wshade", int'(wshade4), 11);
    applyStimulus(1'b0, 4'b0110, 4'd6, 1'b0, 4'd0, 1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("illegal.target", int'(target4), 11);
    checkOutput("illegal.moving", int'(moving4), 0);
    checkOutput("illegal.wshade", int'(wshade4), 11);
    applyStimulus(1'b0, 4'b1000, 4'd6, 1'b0, 4'd0, 1);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("day.target", int'(target4), 0);
    checkOutput("day.wshade", int'(wshade4), 0);

    // Override reversal mid-ramp at wshade 5, prescaler 2.
    applyStimulus(1'b0, 4'b0001, 4'd0, 1'b0, 4'd0, 1);
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk); #1;
    end
    checkOutput("ovr.wshade_before", int'(wshade4), 5);
    applyStimulus(1'b0, 4'b0001, 4'd0, 1'b1, 4'd2, 1);
    for (int f = 1; f <= 14; f++) begin
      @(posedge clk); #1;
      if (f == 1)  checkOutput("ovr.dir_up_f1", int'(dirup4), 1);
      if (f == 2)  checkOutput("ovr.dir_up_f2", int'(dirup4), 0);
      if (f == 2)  checkOutput("ovr.wshade_f2", int'(wshade4), 5);
      if (f == 13) checkOutput("ovr.wshade_f13", int'(wshade4), 3);
      if (f == 14) checkOutput("ovr.wshade_f14", int'(wshade4), 2);
      if (f == 14) checkOutput("ovr.moving_f14", int'(moving4), 0);
    end

    // Reset while ramping up at wshade 7.
    applyStimulus(1'b0, 4'b0001, 4'd0, 1'b0, 4'd0, 1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk); #1;
      if (wshade4 == 4'd7) found = 1'b1;
    end
    if (!found) checkOutput("rstmid.wait_w7", int'(wshade4), 7);
    applyStimulus(1'b1, 4'b0001, 4'd0, 1'b0, 4'd0, 1);
    @(posedge clk); #1;
    checkOutput("rstmid.wshade", int'(wshade4), 0);
    checkOutput("rstmid.target", int'(target4), 0);
    checkOutput("rstmid.moving", int'(moving4), 0);
    checkOutput("rstmid.dir_up", int'(dirup4), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("rstmid.step_pulse", int'(pulse4), 0);
    end

    // Divide-by-one instance: evening ramp counts one level per edge.
    applyStimulus(1'b0, 4'b0010, 4'd0, 1'b0, 4'd0, 1);
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      if (e >= 3 && e <= 13) checkOutput("div1.wshade", int'(wshade1), e - 2);
      if (e >= 3 && e <= 13) checkOutput("div1.step_pulse", int'(pulse1), 1);
      if (e == 13) checkOutput("div1.moving_e13", int'(moving1), 0);
      if (e == 14) checkOutput("div1.step_pulse_e14", int'(pulse1), 0);
    end

    // Randomised traffic checked by the every-cycle compare process.
    for (int it = 0; it < 1500; it++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: tc = 4'b0000;
        1: tc = 4'b0001;
        2: tc = 4'b0010;
        3: tc = 4'b0100;
        4: tc = 4'b1000;
        default: tc = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 99) < 2)
        applyStimulus(1'b1, tc, 4'($urandom_range(0, 15)), 1'b0, 4'd0, $urandom_range(1, 3));
      else
        applyStimulus(1'b0, tc, 4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 20),
                      4'($urandom_range(0, 15)), $urandom_range(1, 30));
    end

    applyStimulus(1'b0, 4'b0000, 4'd0, 1'b0, 4'd0, 2);
    compareOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
